// File: rtl/rwl_pkg.sv
// Shared constants, index widths and state encoding for the bit-serial read-word-line sequencer.
package rwl_pkg;

    localparam int INPUT_WIDTH = 144;
    localparam int GROUP_SIZE  = 12;
    localparam int XBITS       = 8;
    localparam int NUM_GROUPS  = INPUT_WIDTH / GROUP_SIZE;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        if (r < 1) begin
            return 1;
        end else begin
            return r;
        end
    endfunction

    localparam int GRP_W = clog2_min1(NUM_GROUPS);
    localparam int BIT_W = clog2_min1(XBITS);
    localparam int PRE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_PRE   = 2'd2,
        ST_DONE  = 2'd3
    } rwl_state_e;

endpackage

// File: rtl/rwl_plane_mux.sv
// Combinational bit-plane selector: picks bit bit_idx_i of every element, masked to the active group.
module rwl_plane_mux
    import rwl_pkg::*;
(
    input  logic [INPUT_WIDTH*XBITS-1:0] xin_lat_i,
    input  logic [BIT_W-1:0]             bit_idx_i,
    input  logic [GRP_W-1:0]             grp_idx_i,
    input  logic                         mode_all_i,
    output logic [INPUT_WIDTH-1:0]       pattern_o
);

    logic [XBITS-1:0] elem_s;

    // Per-row plane bit, zeroed outside the selected group unless all groups are driven
    always_comb begin
        pattern_o = {INPUT_WIDTH{1'b0}};
        elem_s    = {XBITS{1'b0}};
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            elem_s = xin_lat_i[i*XBITS +: XBITS];
            if (mode_all_i || (GRP_W'(i / GROUP_SIZE) == grp_idx_i)) begin
                pattern_o[i] = elem_s[bit_idx_i];
            end else begin
                pattern_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rwl_bitser_seq.sv
// Read-word-line sequencer: latches xin on start, walks planes MSB-first and groups, one registered
// rwlb pattern per accepted step, with optional all-zero precharge bubbles between steps.
module rwl_bitser_seq
    import rwl_pkg::*;
#(
    parameter int PRE_CYC = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         mode_all,
    input  logic                         row_sel,
    input  logic [INPUT_WIDTH*XBITS-1:0] xin,
    input  logic                         mac_ready,
    output logic [INPUT_WIDTH-1:0]       rwlb_ping,
    output logic [INPUT_WIDTH-1:0]       rwlb_pong,
    output logic                         step_valid,
    output logic                         step_last,
    output logic [BIT_W-1:0]             bit_idx,
    output logic [GRP_W-1:0]             grp_idx,
    output logic                         busy,
    output logic                         done
);

    rwl_state_e                   state_q, state_d;
    logic [BIT_W-1:0]             bit_q, bit_d;
    logic [GRP_W-1:0]             grp_q, grp_d;
    logic [PRE_W-1:0]             pre_q, pre_d;
    logic [INPUT_WIDTH*XBITS-1:0] xin_q, xin_d;
    logic                         mode_q, mode_d;
    logic                         row_q, row_d;
    logic [INPUT_WIDTH-1:0]       ping_q, ping_d, pong_q, pong_d, pat_s;
    logic                         valid_q, valid_d, last_q, last_d;
    logic                         busy_q, busy_d, done_q, done_d;
    logic                         plane_end_s;

    assign plane_end_s = mode_q || (grp_q == GRP_W'(NUM_GROUPS - 1));

    // Sequencing: state, step counters and start-time latches
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        grp_d   = grp_q;
        pre_d   = pre_q;
        xin_d   = xin_q;
        mode_d  = mode_q;
        row_d   = row_q;
        if (abort) begin
            state_d = ST_IDLE;
            bit_d   = {BIT_W{1'b0}};
            grp_d   = {GRP_W{1'b0}};
            pre_d   = {PRE_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_DRIVE;
                        xin_d   = xin;
                        mode_d  = mode_all;
                        row_d   = row_sel;
                        bit_d   = BIT_W'(XBITS - 1);
                        grp_d   = {GRP_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (!mac_ready) begin
                        state_d = ST_DRIVE;
                    end else if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // Advance now so PRE already presents the upcoming step's indices
                        if (plane_end_s) begin
                            grp_d = {GRP_W{1'b0}};
                            bit_d = bit_q - BIT_W'(1);
                        end else begin
                            grp_d = grp_q + GRP_W'(1);
                        end
                        if (PRE_CYC > 0) begin
                            state_d = ST_PRE;
                            pre_d   = PRE_W'(PRE_CYC - 1);
                        end else begin
                            state_d = ST_DRIVE;
                        end
                    end
                end
                ST_PRE: begin
                    if (pre_q == {PRE_W{1'b0}}) begin
                        state_d = ST_DRIVE;
                    end else begin
                        pre_d = pre_q - PRE_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    bit_d   = {BIT_W{1'b0}};
                    grp_d   = {GRP_W{1'b0}};
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Pattern is built from next-state values so the first step appears one cycle after start
    rwl_plane_mux u_mux (
        .xin_lat_i  (xin_d),
        .bit_idx_i  (bit_d),
        .grp_idx_i  (grp_d),
        .mode_all_i (mode_d),
        .pattern_o  (pat_s)
    );

    // Next values of the registered outputs
    always_comb begin
        valid_d = (state_d == ST_DRIVE);
        last_d  = valid_d && (bit_d == {BIT_W{1'b0}}) &&
                  (mode_d || (grp_d == GRP_W'(NUM_GROUPS - 1)));
        busy_d  = (state_d == ST_DRIVE) || (state_d == ST_PRE);
        done_d  = (state_d == ST_DONE);
        if (valid_d && !row_d) begin
            ping_d = pat_s;
        end else begin
            ping_d = {INPUT_WIDTH{1'b0}};
        end
        if (valid_d && row_d) begin
            pong_d = pat_s;
        end else begin
            pong_d = {INPUT_WIDTH{1'b0}};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= {BIT_W{1'b0}};
            grp_q   <= {GRP_W{1'b0}};
            pre_q   <= {PRE_W{1'b0}};
            xin_q   <= {(INPUT_WIDTH*XBITS){1'b0}};
            mode_q  <= 1'b0;
            row_q   <= 1'b0;
            ping_q  <= {INPUT_WIDTH{1'b0}};
            pong_q  <= {INPUT_WIDTH{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            grp_q   <= grp_d;
            pre_q   <= pre_d;
            xin_q   <= xin_d;
            mode_q  <= mode_d;
            row_q   <= row_d;
            ping_q  <= ping_d;
            pong_q  <= pong_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rwlb_ping  = ping_q;
    assign rwlb_pong  = pong_q;
    assign step_valid = valid_q;
    assign step_last  = last_q;
    assign bit_idx    = bit_q;
    assign grp_idx    = grp_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
